// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter driving a 4-to-16 decoder; optional hold timeout via RR_ARB_TIMEOUT_EN.
// Latency: grant registered one edge after req is seen in IDLE; one dead IDLE cycle after each release.
// Backpressure: none; the owner holds the resource until done, its req drops, or the timeout expires.
module rr_arbiter_16 #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_valid,
    output logic [3:0]  grant_index,
    output logic [15:0] grant_onehot
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [3:0]  winner;
    logic        release_now;
`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0]  hold_cnt;
`endif

    // Out-of-range hold limits have no meaningful behaviour; this branch exists only to name the condition.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
    end

    // Scan downward so the smallest offset from the pointer is the last, and winning, assignment.
    always_comb begin
        winner = ptr;
        for (int k = 15; k >= 0; k--) begin
            if (req[ptr + 4'(k)]) begin
                winner = ptr + 4'(k);
            end
        end
    end

    always_comb begin
        release_now = done | ~req[grant_index];
`ifdef RR_ARB_TIMEOUT_EN
        release_now = release_now | (hold_cnt == 8'(HOLD_MAX));
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= 4'h0;
            grant_valid  <= 1'b0;
            grant_index  <= 4'h0;
            grant_onehot <= 16'h0000;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt     <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt <= 8'd0;
`endif
                    if (|req) begin
                        grant_index  <= winner;
                        grant_valid  <= 1'b1;
                        grant_onehot <= 16'h0001 << winner;
                        state        <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt     <= 8'd1;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant_valid  <= 1'b0;
                        grant_onehot <= 16'h0000;
                        ptr          <= grant_index + 4'd1;
                        state        <= IDLE;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt     <= 8'd0;
                    end else begin
                        hold_cnt     <= hold_cnt + 8'd1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-requester round-robin arbiter that shares a single downstream resource selected by a 4-to-16 one-hot decoder. It issues a registered binary grant index plus enable, which drive the decoder's select and enable inputs directly. It also provides a registered one-hot copy for local use. Fairness is round-robin, with an optional hold timeout that forces rotation.

## Interface
- HOLD_MAX, 8: maximum consecutive grant cycles per owner when the timeout is compiled in; legal range 1..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  16  per-requester request, level-sensitive; bit i = requester i.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant_valid  output  1  a grant is active; drives the decoder enable.
- grant_index  output  4  binary index of the owner; drives the decoder select.
- grant_onehot  output  16  one-hot grant; all zero when grant_valid is 0.

## Operation
- Reset values:
  - grant_valid = 0, grant_index = 4'h0, grant_onehot = 16'h0000.
  - State = IDLE, priority pointer = 4'h0, hold counter = 0.
- State IDLE:
  - If req != 0, search from the pointer upward, modulo 16. The first set bit wins.
  - Load grant_index with the winner, set grant_valid, go to GRANT.
  - If req == 0, stay in IDLE. done is ignored.
- State GRANT releases on any of:
  - done = 1;
  - req[grant_index] = 0;
  - hold counter == HOLD_MAX (timeout build only).
- On release:
  - Clear grant_valid and grant_onehot.
  - Pointer = grant_index + 1, 4-bit wrap (15 -> 0).
  - Go to IDLE.
  - Simultaneous release conditions produce a single release.
- After every release the FSM spends exactly one cycle in IDLE with grant_valid = 0. This dead cycle prevents overlapping decoder outputs.
- grant_index holds its last value while grant_valid = 0.
- grant_onehot[i] = grant_valid & (grant_index == i). It is registered with grant_index, so the two never disagree.
- A lone requester is regranted after the dead cycle, because the search wraps back to it.
- Requests arriving or changing during GRANT (other than the owner's own bit) have no effect until the next IDLE.

## Timing
- Request-to-grant: req sampled in IDLE at edge N, so grant_valid is high after edge N.
- Release: condition sampled at edge M, so grant_valid is low after edge M.
  - The earliest next grant is after edge M+1.
- Maximum grant rate: one grant every 2 cycles when the owner releases after one cycle.
- All outputs come from flops; there is no combinational path from req or done to outputs.
- Hold counter (8-bit):
  - Loads 1 on the grant edge and increments each GRANT cycle.
  - With a timeout release, grant_valid stays high for exactly HOLD_MAX cycles.
  - Cleared to 0 in IDLE.
- Asserting reset mid-grant clears all outputs immediately, without waiting for a clock edge.
  - The first grant after reset deassertion searches from requester 0.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - The hold counter and the timeout release are compiled in.
  - An owner that never raises done and keeps req high loses the grant after HOLD_MAX cycles.
- RR_ARB_TIMEOUT_EN not defined:
  - No counter logic is present and HOLD_MAX is unused.
  - A grant persists until done or req[owner] drops.

## Test plan
- Reset mid-grant:
  - Stimulus: req = 16'h0010, granted; reset asserted between clock edges.
  - Response: grant_valid = 0 and grant_onehot = 0 immediately. After release of reset, with req = 16'h8001, the grant goes to index 0.
- Rotation:
  - Stimulus: req = 16'h0005 held; done pulsed one cycle after each grant.
  - Response: grant sequence 0, 2, 0, 2 with one idle cycle between grants; grant_onehot alternates 16'h0001 / 16'h0004.
- Wrap:
  - Stimulus: pointer at 15 (after granting index 14); req = 16'h8002.
  - Response: grant 15 first, then 1. Confirm the pointer goes 15 -> 0.
- Request drop:
  - Stimulus: owner 7 deasserts req[7] while req[3] stays high.
  - Response: grant_valid falls the next edge, one idle cycle follows, then grant_index = 3.
- Timeout (RR_ARB_TIMEOUT_EN defined, HOLD_MAX = 4):
  - Stimulus: req = 16'h0200 held, done = 0.
  - Response: grant_valid high for exactly 4 cycles, low for 1, then index 9 is regranted.
  - The same stimulus without the macro keeps the grant indefinitely.
- Simultaneous release:
  - Stimulus: done = 1 and req[owner] drops on the same cycle.
  - Response: a single release and a single pointer advance.
